jacobi_ram_arbiter: RTL
=======================

// Module: jacobi_ram_arbiter
// PURPOSE
//  Shares the dual-port Jacobi matrix RAM (W and V regions) between three requesters:
//  rotation writeback, angle fetch and host load/readout. Each request is one atomic
//  command covering both RAM ports. Round-robin arbitration, with a lock for bursts.
//  Sits between the main controller/rotation FIFO and the RAM. Returns read data with a valid tag.
// PARAMETERS
//  N_REQ   3                         number of requesters (index 0 = rotation, 1 = angle, 2 = host)
//  ADDR_W  JACOBI_ADDR_WIDTH         RAM address width
//  DATA_W  JACOBI_OUTPUT_WORD_WIDTH  RAM word width
//  RD_LAT  2                         RAM read latency, counted from the cycle the command is on the RAM pins
// PORTS
//  clk          in   1              clock
//  rst          in   1              synchronous, active-high reset
//  req_i        in   N_REQ          request; held with its command until gnt_o
//  lock_i       in   N_REQ          keep ownership after the current grant
//  en_a_i/en_b_i  in  N_REQ         per-requester port enable
//  we_a_i/we_b_i  in  N_REQ         per-requester port write enable
//  addr_a_i/addr_b_i  in  N_REQ*ADDR_W  packed addresses; requester k in slice [k*ADDR_W +: ADDR_W]
//  din_a_i/din_b_i    in  N_REQ*DATA_W  packed write data
//  gnt_o        out  N_REQ          one-hot grant, combinational, same cycle as the request
//  rd_vld_o     out  N_REQ          one-hot read-data valid, routed to the issuing requester
//  rd_dat_a_o/rd_dat_b_o  out  DATA_W   RAM dout passed through, shared by all requesters
//  ram_en_a_o, ram_we_a_o, ram_addr_a_o, ram_din_a_o   out   RAM port A, registered
//  ram_dout_a_i  in  DATA_W         RAM port A read data
//  ram_en_b_o, ram_we_b_o, ram_addr_b_o, ram_din_b_o   out   RAM port B, registered
//  ram_dout_b_i  in  DATA_W         RAM port B read data
//  collision_o  out  1              sticky: a granted command had en_a&en_b, equal addresses, and a write on either port
// BEHAVIOUR
//  Reset: gnt_o = 0, rd_vld_o = 0, all ram_* = 0, collision_o = 0, state = ARB,
//   rr_ptr = 0, lock owner cleared, read tag pipeline flushed.
//  FSM ARB:
//   - Grant the first requester with req set, searching from rr_ptr upwards with wrap.
//   - On a grant, rr_ptr <= winner+1 (mod N_REQ).
//   - If lock_i[winner] is set, go to LOCKED with owner <= winner.
//  FSM LOCKED:
//   - Only the owner can be granted; other requests wait.
//   - Go to ARB when lock_i[owner] = 0, whether or not owner req is set that cycle.
//   - The grant in that cycle still goes to the owner if its req is set.
//   - rr_ptr is not updated while LOCKED.
//  Timing: request granted at cycle t -> command on ram_* at t+1 -> rd_vld_o[k] and
//   valid rd_dat at t+1+RD_LAT.
//  rd_vld_o[k] is raised only if the granted command had a read (en & !we) on either port.
//   Both rd_dat ports are presented; the requester ignores a port it did not read.
//  Tag pipeline depth RD_LAT+1: {valid, id}. One grant per cycle gives full throughput,
//   so back-to-back reads return in order, one per cycle.
//  No grant in a cycle -> ram_en_a/b = 0 and ram_we_a/b = 0 the next cycle.
//   Address and data registers hold their values.
//  Write-only command: no rd_vld is generated.
//  collision_o clears only on rst; the command is still issued unchanged.
//  Reset mid-operation: all in-flight read tags are dropped, so no rd_vld after reset.
//   The RAM contents are not touched.
//  A requester that drops req before gnt (protocol violation) simply loses the slot.
//   The bench asserts this never happens.
// STRUCTURE
//  Additions to package common:
//   - JACOBI_RAM_N_REQ = 3 and JACOBI_RAM_RD_LAT = 2.
//   - typedef enum {REQ_ROT, REQ_ANGLE, REQ_HOST} jacobi_ram_req_t.
//   - typedef enum {ARB, LOCKED} jacobi_arb_fsm_t.
//  One sub-module, jacobi_rr_picker: combinational.
//   Inputs: req vector, pointer. Outputs: one-hot grant, winner index.
//  The FSM, command registers, tag pipeline and collision flag stay in this module.
// TESTING
//  1. Single read: req[1] with en_a = en_b = 1, we = 0, addr_a = 9, addr_b = 1 at cycle 5.
//     Expect gnt[1] at 5, ram_addr_a = 9 at 6, rd_vld[1] at 8 with the RAM model data.
//  2. All three requesters request continuously after reset.
//     Expect the grant order 0, 1, 2, 0, 1, 2; each rd_vld 3 cycles after its gnt.
//  3. Requester 2 sets lock for 64 writes while requester 0 requests.
//     Expect 64 consecutive gnt[2] and gnt[0] on the cycle after lock falls.
//  4. No requests for 4 cycles: ram_en_a/b = 0 and ram_we_a/b = 0 throughout.
//     Write-only command to V region address 64: rd_vld stays 0.
//  5. Command with en_a = en_b = 1, we_a = 1, addr_a = addr_b = 17.
//     Expect collision_o = 1 from the next cycle until rst.
//  6. rst asserted one cycle after a read is granted.
//     Expect no rd_vld; all outputs at their reset values; rr_ptr = 0, so req = 3'b111 grants requester 0.

Source files
------------

// File: rtl/jacobi_ram_arbiter_pkg.sv
// ============================================================================
//  Module   : jacobi_ram_arbiter_pkg
//  Purpose  : Shared constants and types for the Jacobi matrix RAM arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package jacobi_ram_arbiter_pkg;

    localparam int JACOBI_ADDR_WIDTH        = 8;
    localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
    localparam int JACOBI_RAM_N_REQ         = 3;
    localparam int JACOBI_RAM_RD_LAT        = 2;

    typedef enum logic [1:0] {
        REQ_ROT   = 2'd0,
        REQ_ANGLE = 2'd1,
        REQ_HOST  = 2'd2
    } jacobi_ram_req_t;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } jacobi_arb_fsm_t;

endpackage

`default_nettype wire

// File: rtl/jacobi_rr_picker.sv
// ============================================================================
//  Module   : jacobi_rr_picker
//  Purpose  : Combinational round-robin pick: first set request from ptr_i up.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jacobi_rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // ptr_i < N_REQ, so a single subtraction is enough to wrap
            w_sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!any_o && req_i[w_cand]) begin
                any_o         = 1'b1;
                gnt_o[w_cand] = 1'b1;
                idx_o         = w_cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/jacobi_ram_arbiter.sv
// ============================================================================
//  Module   : jacobi_ram_arbiter
//  Purpose  : Round-robin arbiter with burst lock sharing the dual-port Jacobi RAM.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jacobi_ram_arbiter
    import jacobi_ram_arbiter_pkg::*;
#(
    parameter int N_REQ  = JACOBI_RAM_N_REQ,
    parameter int ADDR_W = JACOBI_ADDR_WIDTH,
    parameter int DATA_W = JACOBI_OUTPUT_WORD_WIDTH,
    parameter int RD_LAT = JACOBI_RAM_RD_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         lock_i,
    input  logic [N_REQ-1:0]         en_a_i,
    input  logic [N_REQ-1:0]         en_b_i,
    input  logic [N_REQ-1:0]         we_a_i,
    input  logic [N_REQ-1:0]         we_b_i,
    input  logic [N_REQ*ADDR_W-1:0]  addr_a_i,
    input  logic [N_REQ*ADDR_W-1:0]  addr_b_i,
    input  logic [N_REQ*DATA_W-1:0]  din_a_i,
    input  logic [N_REQ*DATA_W-1:0]  din_b_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [N_REQ-1:0]         rd_vld_o,
    output logic [DATA_W-1:0]        rd_dat_a_o,
    output logic [DATA_W-1:0]        rd_dat_b_o,
    output logic                     ram_en_a_o,
    output logic                     ram_we_a_o,
    output logic [ADDR_W-1:0]        ram_addr_a_o,
    output logic [DATA_W-1:0]        ram_din_a_o,
    input  logic [DATA_W-1:0]        ram_dout_a_i,
    output logic                     ram_en_b_o,
    output logic                     ram_we_b_o,
    output logic [ADDR_W-1:0]        ram_addr_b_o,
    output logic [DATA_W-1:0]        ram_din_b_o,
    input  logic [DATA_W-1:0]        ram_dout_b_i,
    output logic                     collision_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    jacobi_arb_fsm_t r_state, w_state_nxt;
    logic [IDX_W-1:0] r_owner, w_owner_nxt;
    logic [IDX_W-1:0] r_rr_ptr, w_ptr_nxt;

    logic [N_REQ-1:0] w_owner_mask, w_pick_req, w_gnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_any;

    logic              w_en_a, w_en_b, w_we_a, w_we_b, w_rd, w_coll;
    logic [ADDR_W-1:0] w_addr_a, w_addr_b;
    logic [DATA_W-1:0] w_din_a, w_din_b;

    logic              r_en_a, r_en_b, r_we_a, r_we_b, r_coll;
    logic [ADDR_W-1:0] r_addr_a, r_addr_b;
    logic [DATA_W-1:0] r_din_a, r_din_b;

    logic [RD_LAT:0]             r_tag_vld;
    logic [RD_LAT:0][IDX_W-1:0]  r_tag_id;

    // While locked only the owner's request reaches the picker
    assign w_owner_mask = N_REQ'(1) << r_owner;
    assign w_pick_req   = (r_state == LOCKED) ? (req_i & w_owner_mask) : req_i;

    jacobi_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i (w_pick_req),
        .ptr_i (r_rr_ptr),
        .gnt_o (w_gnt),
        .idx_o (w_idx),
        .any_o (w_any)
    );

    assign gnt_o = rst ? '0 : w_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_rr_ptr;
        case (r_state)
            ARB: begin
                if (w_any) begin
                    w_ptr_nxt = (w_idx == IDX_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
                    if (|(lock_i & w_gnt)) begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_idx;
                    end
                end
            end
            LOCKED: begin
                if (!lock_i[r_owner]) begin
                    w_state_nxt = ARB;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        w_en_a   = 1'b0;
        w_en_b   = 1'b0;
        w_we_a   = 1'b0;
        w_we_b   = 1'b0;
        w_addr_a = '0;
        w_addr_b = '0;
        w_din_a  = '0;
        w_din_b  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_en_a   = en_a_i[k];
                w_en_b   = en_b_i[k];
                w_we_a   = we_a_i[k];
                w_we_b   = we_b_i[k];
                w_addr_a = addr_a_i[k*ADDR_W +: ADDR_W];
                w_addr_b = addr_b_i[k*ADDR_W +: ADDR_W];
                w_din_a  = din_a_i[k*DATA_W +: DATA_W];
                w_din_b  = din_b_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_rd   = w_any & ((w_en_a & ~w_we_a) | (w_en_b & ~w_we_b));
    assign w_coll = w_any & w_en_a & w_en_b & (w_addr_a == w_addr_b) & (w_we_a | w_we_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_a    <= 1'b0;
            r_en_b    <= 1'b0;
            r_we_a    <= 1'b0;
            r_we_b    <= 1'b0;
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_din_a   <= '0;
            r_din_b   <= '0;
            r_coll    <= 1'b0;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_en_a    <= w_any & w_en_a;
            r_en_b    <= w_any & w_en_b;
            r_we_a    <= w_any & w_we_a;
            r_we_b    <= w_any & w_we_b;
            // Idle cycles keep the last address/data on the pins
            if (w_any) begin
                r_addr_a <= w_addr_a;
                r_addr_b <= w_addr_b;
                r_din_a  <= w_din_a;
                r_din_b  <= w_din_b;
            end
            r_coll    <= r_coll | w_coll;
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_rd};
            r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_idx};
        end
    end

    always_comb begin
        rd_vld_o = '0;
        if (r_tag_vld[RD_LAT]) begin
            rd_vld_o[r_tag_id[RD_LAT]] = 1'b1;
        end
    end

    assign rd_dat_a_o   = ram_dout_a_i;
    assign rd_dat_b_o   = ram_dout_b_i;
    assign ram_en_a_o   = r_en_a;
    assign ram_we_a_o   = r_we_a;
    assign ram_addr_a_o = r_addr_a;
    assign ram_din_a_o  = r_din_a;
    assign ram_en_b_o   = r_en_b;
    assign ram_we_b_o   = r_we_b;
    assign ram_addr_b_o = r_addr_b;
    assign ram_din_b_o  = r_din_b;
    assign collision_o  = r_coll;

endmodule

`default_nettype wire
